// File: rtl/cycle_sequencer_pkg.sv
// Shared widths, phase encodings and opcode decode patterns for the
// four-phase instruction cycle sequencer.
package cycle_sequencer_pkg;

  localparam int PC_W        = 11;
  localparam int OP_W        = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = $clog2(STACK_DEPTH);
  localparam int DEPTH_W     = SP_W + 1;

  localparam logic [3:0] Q1_OH = 4'b0001;
  localparam logic [3:0] Q2_OH = 4'b0010;
  localparam logic [3:0] Q3_OH = 4'b0100;
  localparam logic [3:0] Q4_OH = 4'b1000;

  typedef enum logic [3:0] {
    PH_Q1 = Q1_OH,
    PH_Q2 = Q2_OH,
    PH_Q3 = Q3_OH,
    PH_Q4 = Q4_OH
  } phase_t;

  localparam logic [OP_W-1:0] GOTO_MASK    = 14'h3800;
  localparam logic [OP_W-1:0] GOTO_MATCH   = 14'h2800;
  localparam logic [OP_W-1:0] CALL_MASK    = 14'h3800;
  localparam logic [OP_W-1:0] CALL_MATCH   = 14'h2000;
  localparam logic [OP_W-1:0] RETURN_MASK  = 14'h3FFF;
  localparam logic [OP_W-1:0] RETURN_MATCH = 14'h0008;
  localparam logic [OP_W-1:0] FSZ_MASK     = 14'h3F00;
  localparam logic [OP_W-1:0] DECFSZ_MATCH = 14'h0B00;
  localparam logic [OP_W-1:0] INCFSZ_MATCH = 14'h0F00;
  localparam logic [OP_W-1:0] BIT_MASK     = 14'h3C00;
  localparam logic [OP_W-1:0] BTFSC_MATCH  = 14'h1800;
  localparam logic [OP_W-1:0] BTFSS_MATCH  = 14'h1C00;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_GOTO,
    OP_CALL,
    OP_RETURN,
    OP_SKIP
  } op_class_t;

  function automatic op_class_t decode_op(input logic [OP_W-1:0] op);
    op_class_t cls;
    cls = OP_SEQ;
    if ((op & GOTO_MASK) == GOTO_MATCH)
      cls = OP_GOTO;
    else if ((op & CALL_MASK) == CALL_MATCH)
      cls = OP_CALL;
    else if ((op & RETURN_MASK) == RETURN_MATCH)
      cls = OP_RETURN;
    else if (((op & FSZ_MASK) == DECFSZ_MATCH) || ((op & FSZ_MASK) == INCFSZ_MATCH) ||
             ((op & BIT_MASK) == BTFSC_MATCH)  || ((op & BIT_MASK) == BTFSS_MATCH))
      cls = OP_SKIP;
    return cls;
  endfunction

endpackage

// File: rtl/call_stack.sv
// Circular 8-entry return-address stack: overflow overwrites the oldest entry,
// underflow still returns the slot under the wrapped pointer.
module call_stack
  import cycle_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [PC_W-1:0]    din,
  output logic [PC_W-1:0]    top,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf,
  output logic               unf
);

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_top;

  // sp points at the next free slot; the top of stack sits one below it
  assign sp_top = sp - SP_W'(1);
  assign top    = mem[sp_top];

  always_ff @(posedge clk) begin
    if (push)
      mem[sp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
      if (depth == FULL)
        ovf <= 1'b1;
      else
        depth <= depth + DEPTH_W'(1);
    end else if (pop) begin
      sp <= sp_top;
      if (depth == '0)
        unf <= 1'b1;
      else
        depth <= depth - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Four-phase instruction cycle sequencer with fetch/execute overlap,
// control-flow flush and a circular call stack.
//   state | meaning
//   PH_Q1 | decode / operand read
//   PH_Q2 | execute
//   PH_Q3 | write back
//   PH_Q4 | cycle end; boundary edge when hold=0, stall while hold=1
module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               skip_cond,
  input  logic               hold,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         q,
  output logic [OP_W-1:0]    ir,
  output logic               exec_valid,
  output logic               ir_load,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_ovf,
  output logic               stack_unf
);

  phase_t          phase;
  op_class_t       op_class;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] stk_top;
  logic            ev_next;
  logic            do_push;
  logic            do_pop;

  assign q        = phase;
  assign ir_load  = q[3] & ~hold;
  assign op_class = decode_op(ir);
  assign pc_inc   = pc + PC_W'(1);

  // A flushed cycle ignores its instruction entirely, including skip_cond
  always_comb begin
    pc_next = pc_inc;
    ev_next = 1'b1;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (exec_valid) begin
      case (op_class)
        OP_GOTO: begin
          pc_next = ir[PC_W-1:0];
          ev_next = 1'b0;
        end
        OP_CALL: begin
          pc_next = ir[PC_W-1:0];
          ev_next = 1'b0;
          do_push = 1'b1;
        end
        OP_RETURN: begin
          pc_next = stk_top;
          ev_next = 1'b0;
          do_pop  = 1'b1;
        end
        OP_SKIP: begin
          if (skip_cond)
            ev_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= PH_Q1;
      pc         <= '0;
      ir         <= '0;
      exec_valid <= 1'b0;
    end else begin
      case (phase)
        PH_Q1: phase <= PH_Q2;
        PH_Q2: phase <= PH_Q3;
        PH_Q3: phase <= PH_Q4;
        PH_Q4: begin
          if (!hold) begin
            phase      <= PH_Q1;
            pc         <= pc_next;
            ir         <= opcode;
            exec_valid <= ev_next;
          end
        end
        default: phase <= PH_Q1;
      endcase
    end
  end

  call_stack u_call_stack (
    .clk   (clk),
    .reset (reset),
    .push  (ir_load & do_push),
    .pop   (ir_load & do_pop),
    .din   (pc),
    .top   (stk_top),
    .depth (depth),
    .ovf   (stack_ovf),
    .unf   (stack_unf)
  );

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: ROM model driven from pc, hand-computed
// expectations per scenario.
module tb_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] opcode;
  logic        skip_cond;
  logic        hold;
  logic [10:0] pc;
  logic [3:0]  q;
  logic [13:0] ir;
  logic        exec_valid;
  logic        ir_load;
  logic [3:0]  depth;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [0:2047];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign opcode = rom[pc];

  cycle_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .skip_cond  (skip_cond),
    .hold       (hold),
    .pc         (pc),
    .q          (q),
    .ir         (ir),
    .exec_valid (exec_valid),
    .ir_load    (ir_load),
    .depth      (depth),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    hold  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    clocks(4 * n);
  endtask

  task automatic test_reset();
    clear_rom();
    skip_cond = 1'b0;
    hold      = 1'b0;
    reset     = 1'b1;
    #12;
    checks++; if (q !== 4'b0001) begin failures++; $display("FAIL reset_q: got %b exp 0001", q); end
    checks++; if (pc !== 11'd0) begin failures++; $display("FAIL reset_pc: got %h exp 0", pc); end
    checks++; if (ir !== 14'd0) begin failures++; $display("FAIL reset_ir: got %h exp 0", ir); end
    checks++; if (exec_valid !== 1'b0) begin failures++; $display("FAIL reset_ev: got %b exp 0", exec_valid); end
    checks++; if (depth !== 4'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      failures++; $display("FAIL reset_stack: depth %0d ovf %b unf %b exp 0 0 0", depth, stack_ovf, stack_unf); end
    checks++; if (ir_load !== 1'b0) begin failures++; $display("FAIL reset_ir_load: got %b exp 0", ir_load); end
  endtask

  task automatic test_phase();
    logic [3:0] one;
    logic [3:0] eq;
    one = 4'b0001;
    clear_rom();
    apply_reset();
    checks++; if (exec_valid !== 1'b0) begin failures++; $display("FAIL phase_ev_first: got %b exp 0", exec_valid); end
    for (int i = 0; i < 12; i++) begin
      clocks(1);
      eq = one << ((i + 1) % 4);
      checks++; if (q !== eq) begin failures++; $display("FAIL phase_q step %0d: got %b exp %b", i, q, eq); end
      if (eq == 4'b1000) begin
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL phase_ir_load step %0d: got %b exp 1", i, ir_load); end
      end
      if (eq == 4'b0001) begin
        checks++; if (pc !== 11'((i + 1) / 4)) begin failures++; $display("FAIL phase_pc step %0d: got %0d exp %0d", i, pc, (i + 1) / 4); end
        checks++; if (exec_valid !== 1'b1) begin failures++; $display("FAIL phase_ev step %0d: got %b exp 1", i, exec_valid); end
      end
    end
  endtask

  task automatic test_goto();
    clear_rom();
    rom[2]     = 14'h2900;
    rom[3]     = 14'h0333;
    rom[11'h100] = 14'h0123;
    apply_reset();
    run_cycles(4);
    checks++; if (pc !== 11'h100) begin failures++; $display("FAIL goto_pc: got %h exp 100", pc); end
    checks++; if (exec_valid !== 1'b0) begin failures++; $display("FAIL goto_flush: got %b exp 0", exec_valid); end
    checks++; if (ir !== 14'h0333) begin failures++; $display("FAIL goto_ir_flushed: got %h exp 0333", ir); end
    run_cycles(1);
    checks++; if (ir !== 14'h0123 || exec_valid !== 1'b1) begin
      failures++; $display("FAIL goto_target: ir %h ev %b exp 0123 1", ir, exec_valid); end
    checks++; if (pc !== 11'h101) begin failures++; $display("FAIL goto_pc_next: got %h exp 101", pc); end
  endtask

  task automatic test_call_return();
    clear_rom();
    rom[5]      = 14'h2050;
    rom[6]      = 14'h0066;
    rom[11'h050] = 14'h0008;
    rom[11'h051] = 14'h0051;
    apply_reset();
    run_cycles(7);
    checks++; if (pc !== 11'h050 || depth !== 4'd1 || exec_valid !== 1'b0) begin
      failures++; $display("FAIL call: pc %h depth %0d ev %b exp 050 1 0", pc, depth, exec_valid); end
    run_cycles(1);
    checks++; if (ir !== 14'h0008 || exec_valid !== 1'b1) begin
      failures++; $display("FAIL call_target: ir %h ev %b exp 0008 1", ir, exec_valid); end
    run_cycles(1);
    checks++; if (pc !== 11'd6 || depth !== 4'd0 || exec_valid !== 1'b0) begin
      failures++; $display("FAIL return: pc %h depth %0d ev %b exp 006 0 0", pc, depth, exec_valid); end
    checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      failures++; $display("FAIL return_flags: ovf %b unf %b exp 0 0", stack_ovf, stack_unf); end
    run_cycles(1);
    checks++; if (ir !== 14'h0066 || exec_valid !== 1'b1 || pc !== 11'd7) begin
      failures++; $display("FAIL return_resume: ir %h ev %b pc %h exp 0066 1 007", ir, exec_valid, pc); end
  endtask

  task automatic test_skip();
    logic [13:0] sk_op   [6] = '{14'h1C12, 14'h1C12, 14'h1812, 14'h0B12, 14'h0F12, 14'h0A12};
    logic        sk_cond [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        sk_ev   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      clear_rom();
      rom[10] = sk_op[k];
      rom[11] = 14'h0011;
      rom[12] = 14'h0012;
      skip_cond = sk_cond[k];
      apply_reset();
      run_cycles(12);
      checks++; if (ir !== 14'h0011 || exec_valid !== sk_ev[k] || pc !== 11'd12) begin
        failures++; $display("FAIL skip case %0d: ir %h ev %b pc %0d exp 0011 %b 12", k, ir, exec_valid, pc, sk_ev[k]); end
      run_cycles(1);
      checks++; if (ir !== 14'h0012 || exec_valid !== 1'b1 || pc !== 11'd13) begin
        failures++; $display("FAIL skip_next case %0d: ir %h ev %b pc %0d exp 0012 1 13", k, ir, exec_valid, pc); end
    end
    skip_cond = 1'b0;
  endtask

  task automatic test_stack_limits();
    clear_rom();
    for (int j = 0; j < 9; j++) rom[j * 16] = 14'h2000 | 14'((j + 1) * 16);
    apply_reset();
    run_cycles(16);
    checks++; if (depth !== 4'd8 || stack_ovf !== 1'b0 || pc !== 11'h080) begin
      failures++; $display("FAIL stack_full: depth %0d ovf %b pc %h exp 8 0 080", depth, stack_ovf, pc); end
    run_cycles(2);
    checks++; if (depth !== 4'd8 || stack_ovf !== 1'b1 || pc !== 11'h090) begin
      failures++; $display("FAIL stack_ovf: depth %0d ovf %b pc %h exp 8 1 090", depth, stack_ovf, pc); end
    checks++; if (stack_unf !== 1'b0) begin failures++; $display("FAIL stack_ovf_unf: got %b exp 0", stack_unf); end
    run_cycles(3);
    checks++; if (stack_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b exp 1", stack_ovf); end

    clear_rom();
    rom[0] = 14'h0008;
    apply_reset();
    checks++; if (stack_ovf !== 1'b0) begin failures++; $display("FAIL ovf_reset_clear: got %b exp 0", stack_ovf); end
    run_cycles(2);
    checks++; if (stack_unf !== 1'b1 || depth !== 4'd0 || exec_valid !== 1'b0) begin
      failures++; $display("FAIL stack_unf: unf %b depth %0d ev %b exp 1 0 0", stack_unf, depth, exec_valid); end
    run_cycles(2);
    checks++; if (stack_unf !== 1'b1 || depth !== 4'd0) begin
      failures++; $display("FAIL unf_sticky: unf %b depth %0d exp 1 0", stack_unf, depth); end
  endtask

  task automatic test_hold();
    clear_rom();
    rom[0] = 14'h0101;
    rom[1] = 14'h0202;
    apply_reset();
    run_cycles(1);
    clocks(3);
    hold = 1'b1;
    #1;
    checks++; if (ir_load !== 1'b0) begin failures++; $display("FAIL hold_ir_load: got %b exp 0", ir_load); end
    clocks(5);
    checks++; if (q !== 4'b1000 || pc !== 11'd1 || ir !== 14'h0101) begin
      failures++; $display("FAIL hold_frozen: q %b pc %0d ir %h exp 1000 1 0101", q, pc, ir); end
    hold = 1'b0;
    #1;
    checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL hold_release_ir_load: got %b exp 1", ir_load); end
    clocks(1);
    checks++; if (q !== 4'b0001 || pc !== 11'd2 || ir !== 14'h0202) begin
      failures++; $display("FAIL hold_resume: q %b pc %0d ir %h exp 0001 2 0202", q, pc, ir); end
    clocks(1);
    hold = 1'b1;
    clocks(1);
    checks++; if (q !== 4'b0100) begin failures++; $display("FAIL hold_ignored_q2: got %b exp 0100", q); end
    clocks(1);
    checks++; if (q !== 4'b1000) begin failures++; $display("FAIL hold_reach_q4: got %b exp 1000", q); end
    clocks(1);
    checks++; if (q !== 4'b1000 || pc !== 11'd2) begin failures++; $display("FAIL hold_stall_q4: q %b pc %0d exp 1000 2", q, pc); end
    reset = 1'b1;
    #1;
    checks++; if (q !== 4'b0001 || pc !== 11'd0) begin failures++; $display("FAIL hold_reset: q %b pc %0d exp 0001 0", q, pc); end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 14'h0101;
    apply_reset();
    run_cycles(2);
    clocks(2);
    checks++; if (q !== 4'b0100 || pc !== 11'd2) begin failures++; $display("FAIL mid_setup: q %b pc %0d exp 0100 2", q, pc); end
    reset = 1'b1;
    #1;
    checks++; if (q !== 4'b0001 || pc !== 11'd0 || ir !== 14'd0 || exec_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset: q %b pc %0d ir %h ev %b exp 0001 0 0000 0", q, pc, ir, exec_valid); end
    apply_reset();
    clocks(3);
    checks++; if (q !== 4'b1000 || pc !== 11'd0) begin failures++; $display("FAIL mid_pre_boundary: q %b pc %0d exp 1000 0", q, pc); end
    clocks(1);
    checks++; if (pc !== 11'd1 || ir !== 14'h0101 || exec_valid !== 1'b1) begin
      failures++; $display("FAIL mid_first_boundary: pc %0d ir %h ev %b exp 1 0101 1", pc, ir, exec_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    skip_cond = 1'b0;
    test_reset();
    test_phase();
    test_goto();
    test_call_return();
    test_skip();
    test_stack_limits();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
